data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
Responder end of the memory-stage data-memory request interface. It accepts a word-addressed read or write request, with byte enables and load type, and holds the pipeline via stall while a configurable number of wait states elapse. It then performs the access on an internal word-wide RAM and returns load data, sign- or zero-extended per funct3. It sits between the memory stage register outputs and the writeback stage.

Parameters:
ADDR_W, 10, number of word-address bits decoded; RAM depth is 2**ADDR_W words of 32 bits.
WAIT_STATES, 1, extra busy cycles before each access; legal range 0..7.

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  synchronous reset, active-high
read_from_memory  in  1  load request
write_from_memory  in  1  store request
memory_addr  in  30  word address; bits above ADDR_W-1 are ignored (aliasing)
data_to_write  in  32  store data, already lane-aligned
byte_enable_from_memory  in  4  store byte lanes; bit i writes bits [8i+7:8i]
funct3_from_memory  in  3  load type
byte_offset  in  2  low two bits of the effective address
stall  out  1  hold the memory stage; request accepted and not yet complete
data_valid  out  1  one-cycle completion pulse, for both loads and stores
read_data  out  32  extended load data; 0 for stores and errors
err_misaligned  out  1  one-cycle pulse with data_valid when the access was rejected

Behaviour:
- Reset (rst=1 at a clk edge):
  - state goes to IDLE; busy counter to 0.
  - data_valid, err_misaligned and read_data all go to 0.
  - stall is forced to 0 while rst=1.
  - RAM contents are not cleared.
- Request: req = read_from_memory | write_from_memory.
- Both request inputs high: treat as an error. No access; complete through the normal path with err_misaligned=1.
- FSM states:
  - IDLE: if req, capture addr, data, byte enables, funct3, offset and op into internal registers; counter <= WAIT_STATES; go to BUSY. Otherwise stay in IDLE.
  - BUSY: if counter != 0, decrement. If counter == 0, perform the access and go to DONE.
  - DONE: data_valid=1 for exactly this cycle; read_data and err_misaligned are valid. Inputs are ignored. Next state is IDLE unconditionally.
- stall (combinational) = (state==IDLE & req) | (state==BUSY). stall is 0 in DONE, so the memory stage advances at the end of DONE. The stale request held during DONE is therefore never re-accepted.
- Latency: request first seen in IDLE at cycle 0 -> BUSY for cycles 1..WAIT_STATES+1 -> DONE at cycle WAIT_STATES+2. Throughput is one access per WAIT_STATES+3 cycles.
- Store: write each enabled byte lane of ram[addr]; lanes not enabled are unchanged. byte_enable=0000 completes normally with no write. read_data=0.
- Load (funct3, byte_offset): the word is read at the access cycle and extraction is registered into read_data on entry to DONE.
  - 000 lb: sign-extend byte[offset].
  - 100 lbu: zero-extend byte[offset].
  - 001 lh: sign-extend half[offset[1]].
  - 101 lhu: zero-extend half[offset[1]].
  - 010 lw: full word.
- Load errors: a misaligned load (lh/lhu with offset[0]=1, lw with offset!=0) or any other funct3 skips the RAM read. Result is read_data=0 and err_misaligned=1 in DONE.
- Stores are never flagged misaligned; byte enables are trusted.
- Reset during BUSY: the captured request is discarded. A store not yet performed never writes. No data_valid is produced.
- Read-after-write: a store completes in its access cycle, so a following load to the same address returns the new data.

Test Plan:
- WAIT_STATES=0: sw addr 0x10, data 0xDEADBEEF, be 1111; then lw addr 0x10, offset 0 -> stall high cycles 0..1, data_valid at cycle 2, read_data=0xDEADBEEF.
- With word 0x10 = 0x80FF7F01: lb offset 1 -> 0x0000007F; lb offset 2 -> 0xFFFFFFFF; lbu offset 3 -> 0x00000080; lh offset 2 -> 0xFFFF80FF; lhu offset 2 -> 0x000080FF.
- Store 0x0000AB00 with be 0010 over 0x11223344, then lw -> 0x1122AB44.
- lw offset 2, and lh offset 1 -> no RAM read; read_data=0, err_misaligned pulses with data_valid.
- WAIT_STATES=3: sw issued; rst=1 on the second BUSY cycle -> no data_valid, stall=0, later lw returns the old word unchanged.
- WAIT_STATES=2: four back-to-back loads held per stall -> exactly four data_valid pulses, 5 cycles apart; no duplicate access from DONE.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the memory-stage data-memory request interface.
//   Accepts one word-addressed load/store, holds the pipeline via stall for
//   WAIT_STATES extra cycles, performs the access on an internal 32-bit RAM,
//   and returns sign/zero-extended load data with a one-cycle completion pulse.
//
// Ports
//   clk                      clock, rising edge
//   rst                      synchronous reset, active-high (RAM not cleared)
//   read_from_memory         load request
//   write_from_memory        store request (both high = rejected request)
//   memory_addr[29:0]        word address; bits above ADDR_W-1 alias
//   data_to_write[31:0]      lane-aligned store data
//   byte_enable_from_memory  store byte lanes
//   funct3_from_memory[2:0]  load type (lb/lh/lw/lbu/lhu)
//   byte_offset[1:0]         low two bits of the effective address
//   stall                    request accepted and not yet complete
//   data_valid               one-cycle completion pulse
//   read_data[31:0]          extended load data; 0 for stores and errors
//   err_misaligned           one-cycle pulse with data_valid on rejection
module data_mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_from_memory,
  input  logic        write_from_memory,
  input  logic [29:0] memory_addr,
  input  logic [31:0] data_to_write,
  input  logic [3:0]  byte_enable_from_memory,
  input  logic [2:0]  funct3_from_memory,
  input  logic [1:0]  byte_offset,
  output logic        stall,
  output logic        data_valid,
  output logic [31:0] read_data,
  output logic        err_misaligned
);

  localparam logic [2:0] WAIT_INIT = WAIT_STATES[2:0];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t              r_state;
  logic [2:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic [2:0]          r_funct3;
  logic [1:0]          r_off;
  logic                r_is_write;
  logic                r_both;

  logic [31:0]         r_mem [2**ADDR_W];

  logic                w_req;
  logic                w_access;
  logic                w_do_write;
  logic [31:0]         w_word;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load_data;
  logic                w_load_err;
  logic                w_unused_addr;

  assign w_req         = read_from_memory | write_from_memory;
  assign w_unused_addr = ^memory_addr[29:ADDR_W];

  // Access cycle: last BUSY cycle. Gated by rst so a reset in BUSY
  // discards a pending store before it reaches the RAM.
  assign w_access   = (r_state == ST_BUSY) && (r_cnt == 3'd0) && !rst;
  assign w_do_write = w_access && r_is_write && !r_both;

  always_comb begin
    stall = 1'b0;
    if (!rst)
      stall = ((r_state == ST_IDLE) && w_req) || (r_state == ST_BUSY);
  end

  // Load extraction from the addressed word.
  always_comb begin
    w_word      = r_mem[r_addr];
    w_byte      = 8'(w_word >> {r_off, 3'b000});
    w_half      = r_off[1] ? w_word[31:16] : w_word[15:0];
    w_load_data = '0;
    w_load_err  = 1'b0;
    unique case (r_funct3)
      3'b000: w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100: w_load_data = {24'd0, w_byte};
      3'b001: begin
        if (r_off[0]) w_load_err  = 1'b1;
        else          w_load_data = {{16{w_half[15]}}, w_half};
      end
      3'b101: begin
        if (r_off[0]) w_load_err  = 1'b1;
        else          w_load_data = {16'd0, w_half};
      end
      3'b010: begin
        if (r_off != 2'd0) w_load_err  = 1'b1;
        else               w_load_data = w_word;
      end
      default: w_load_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      data_valid     <= 1'b0;
      err_misaligned <= 1'b0;
      read_data      <= '0;
    end else begin
      data_valid     <= 1'b0;
      err_misaligned <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr     <= memory_addr[ADDR_W-1:0];
            r_wdata    <= data_to_write;
            r_be       <= byte_enable_from_memory;
            r_funct3   <= funct3_from_memory;
            r_off      <= byte_offset;
            r_is_write <= write_from_memory;
            r_both     <= read_from_memory & write_from_memory;
            r_cnt      <= WAIT_INIT;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            r_state    <= ST_DONE;
            data_valid <= 1'b1;
            if (r_both) begin
              err_misaligned <= 1'b1;
              read_data      <= '0;
            end else if (r_is_write) begin
              read_data <= '0;
            end else begin
              err_misaligned <= w_load_err;
              read_data      <= w_load_err ? '0 : w_load_data;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[r_addr][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule
